// File: rtl/exp_aligner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exp_aligner_pkg
// Purpose  : Shared widths and state encoding for the FP32 multi-operand
//            adder front end (exponent aligner and its shifter).
// Contents : EXP_W, FRAC_W, MANT_W, HIDDEN_POS, GUARD_W, state_t
// Revision : 1.0 - initial release
// ============================================================================
package exp_aligner_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int MANT_W     = 50;
    localparam int HIDDEN_POS = 46;
    localparam int GUARD_W    = 23;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/exp_aligner_shifter.sv
`default_nettype none
// ============================================================================
// Module   : align_shifter
// Purpose  : Combinational right shift of a 24-bit significand placed at
//            bits [46:23] of a 50-bit magnitude, with sticky collection
//            into bit 0.
// Ports    : i_m   [23:0] significand {hidden, frac}
//            i_d   [7:0]  right-shift distance
//            o_mag [49:0] aligned magnitude
// Revision : 1.0 - initial release
// ============================================================================
module align_shifter
    import exp_aligner_pkg::*;
(
    input  logic [FRAC_W:0]   i_m,
    input  logic [EXP_W-1:0]  i_d,
    output logic [MANT_W-1:0] o_mag
);

    localparam logic [MANT_W-1:0] c_STICKY_ONLY = {{(MANT_W-1){1'b0}}, 1'b1};

    logic [MANT_W-1:0] w_placed;
    logic [MANT_W-1:0] w_shifted;
    logic [MANT_W-1:0] w_lost;

    always_comb begin
        // Three headroom bits above the hidden one, guard field below it.
        w_placed  = {{(MANT_W-HIDDEN_POS-1){1'b0}}, i_m, {GUARD_W{1'b0}}};
        w_shifted = w_placed >> i_d;
        // Bits that fall below bit 0 are exactly those under the low mask.
        w_lost    = w_placed & ~({MANT_W{1'b1}} << i_d);
        if (i_d >= EXP_W'(MANT_W)) begin
            o_mag = c_STICKY_ONLY;
        end else begin
            o_mag = w_shifted | {{(MANT_W-1){1'b0}}, |w_lost};
        end
    end

endmodule
`default_nettype wire

// File: rtl/exp_aligner.sv
`default_nettype none
// ============================================================================
// Module   : exp_aligner
// Purpose  : Collects a batch of up to DEPTH float32 operands, tracks the
//            batch maximum exponent, then emits every operand as sign plus
//            a 50-bit magnitude right-aligned to that maximum.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready/in_data[31:0]/in_last   operand input
//            out_valid/out_ready                       output handshake
//            out_sign, out_mant[49:0], out_exp_max[7:0],
//            out_last, out_special                     aligned operand
// Revision : 1.0 - initial release
// ============================================================================
module exp_aligner
    import exp_aligner_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp_max,
    output logic              out_last,
    output logic              out_special
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_CLOSE = c_CNT_W'(DEPTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [c_IDX_W-1:0] r_idx;
    logic [EXP_W-1:0]   r_exp_max;
    logic               r_special;
    logic [31:0]        r_buf [DEPTH];

    logic               r_out_valid;
    logic               r_out_sign;
    logic [MANT_W-1:0]  r_out_mant;
    logic [EXP_W-1:0]   r_out_exp_max;
    logic               r_out_last;
    logic               r_out_special;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [EXP_W-1:0]   w_exp_max_nxt;
    logic               w_special_nxt;
    logic               w_out_valid_nxt;
    logic               w_out_sign_nxt;
    logic [MANT_W-1:0]  w_out_mant_nxt;
    logic [EXP_W-1:0]   w_out_exp_max_nxt;
    logic               w_out_last_nxt;
    logic               w_out_special_nxt;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_close;
    logic [EXP_W-1:0]   w_in_exp;
    logic [EXP_W-1:0]   w_exp_max_upd;
    logic               w_special_upd;
    logic [c_IDX_W-1:0] w_idx_inc;

    logic [31:0]        w_src;
    logic [EXP_W-1:0]   w_src_exp;
    logic [EXP_W-1:0]   w_src_exp_max;
    logic [EXP_W-1:0]   w_d;
    logic [FRAC_W:0]    w_m;
    logic [MANT_W-1:0]  w_shift_mag;
    logic [MANT_W-1:0]  w_src_mag;

    assign in_ready = (r_state == COLLECT);

    always_comb begin
        w_in_exp      = in_data[30:23];
        w_in_fire     = in_valid && (r_state == COLLECT);
        w_out_fire    = r_out_valid && out_ready;
        // exp==0 can never exceed the running max, so zeros/denormals drop out.
        w_exp_max_upd = (w_in_exp > r_exp_max) ? w_in_exp : r_exp_max;
        w_special_upd = r_special || (w_in_exp == {EXP_W{1'b1}});
        w_close       = in_last || (r_count == c_CNT_CLOSE);
        w_idx_inc     = r_idx + c_IDX_ONE;

        // The aligner always works on the operand the output register
        // loads next: buf[0] (or the word arriving now when it is the
        // only one) at batch close, buf[idx+1] while emitting.
        if (r_state == COLLECT) begin
            w_src         = (r_count == '0) ? in_data : r_buf[0];
            w_src_exp_max = w_exp_max_upd;
        end else begin
            w_src         = r_buf[w_idx_inc];
            w_src_exp_max = r_exp_max;
        end
        w_src_exp = w_src[30:23];
        w_d       = w_src_exp_max - w_src_exp;
        w_m       = {(w_src_exp != '0), w_src[FRAC_W-1:0]};
    end

    align_shifter u_shifter (
        .i_m   (w_m),
        .i_d   (w_d),
        .o_mag (w_shift_mag)
    );

    // Zero and denormal operands are flushed to a zero magnitude.
    assign w_src_mag = (w_src_exp == '0) ? '0 : w_shift_mag;

    // ------------------------------------------------------------------
    // Next-state / output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_idx_nxt         = r_idx;
        w_exp_max_nxt     = r_exp_max;
        w_special_nxt     = r_special;
        w_out_valid_nxt   = r_out_valid;
        w_out_sign_nxt    = r_out_sign;
        w_out_mant_nxt    = r_out_mant;
        w_out_exp_max_nxt = r_out_exp_max;
        w_out_last_nxt    = r_out_last;
        w_out_special_nxt = r_out_special;

        case (r_state)
            COLLECT: begin
                if (w_in_fire) begin
                    w_count_nxt   = r_count + c_CNT_ONE;
                    w_exp_max_nxt = w_exp_max_upd;
                    w_special_nxt = w_special_upd;
                    if (w_close) begin
                        w_state_nxt       = EMIT;
                        w_idx_nxt         = '0;
                        w_out_valid_nxt   = 1'b1;
                        w_out_sign_nxt    = w_src[31];
                        w_out_mant_nxt    = w_src_mag;
                        w_out_exp_max_nxt = w_exp_max_upd;
                        w_out_last_nxt    = (r_count == '0);
                        w_out_special_nxt = w_special_upd;
                    end
                end
            end
            EMIT: begin
                if (w_out_fire) begin
                    if (r_out_last) begin
                        w_state_nxt       = COLLECT;
                        w_count_nxt       = '0;
                        w_idx_nxt         = '0;
                        w_exp_max_nxt     = '0;
                        w_special_nxt     = 1'b0;
                        w_out_valid_nxt   = 1'b0;
                        w_out_sign_nxt    = 1'b0;
                        w_out_mant_nxt    = '0;
                        w_out_exp_max_nxt = '0;
                        w_out_last_nxt    = 1'b0;
                        w_out_special_nxt = 1'b0;
                    end else begin
                        w_idx_nxt       = w_idx_inc;
                        w_out_valid_nxt = 1'b1;
                        w_out_sign_nxt  = w_src[31];
                        w_out_mant_nxt  = w_src_mag;
                        w_out_last_nxt  = ({1'b0, w_idx_inc} == (r_count - c_CNT_ONE));
                    end
                end
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= COLLECT;
            r_count       <= '0;
            r_idx         <= '0;
            r_exp_max     <= '0;
            r_special     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sign    <= 1'b0;
            r_out_mant    <= '0;
            r_out_exp_max <= '0;
            r_out_last    <= 1'b0;
            r_out_special <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_idx         <= w_idx_nxt;
            r_exp_max     <= w_exp_max_nxt;
            r_special     <= w_special_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_sign    <= w_out_sign_nxt;
            r_out_mant    <= w_out_mant_nxt;
            r_out_exp_max <= w_out_exp_max_nxt;
            r_out_last    <= w_out_last_nxt;
            r_out_special <= w_out_special_nxt;
        end
    end

    // Operand buffer; the write slot is the running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_in_fire) begin
            r_buf[r_count[c_IDX_W-1:0]] <= in_data;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_sign    = r_out_sign;
    assign out_mant    = r_out_mant;
    assign out_exp_max = r_out_exp_max;
    assign out_last    = r_out_last;
    assign out_special = r_out_special;

endmodule
`default_nettype wire
